// File: rtl/gf8_oka_mul_pipe.sv
// Three-stage GF(2^8) multiplier: operand capture, one-level Karatsuba carry-less product, modular reduction.
// Define GF8_MAC_EN to add in_last and XOR-accumulate products into one result per frame.
`timescale 1ns/1ps
module gf8_oka_mul_pipe #(
  parameter logic [8:0] POLY  = 9'h11B,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
`ifdef GF8_MAC_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_y,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  function automatic logic [6:0] clmul4(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ ({3'b000, x} << i);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_reduce(input logic [14:0] p);
    logic [14:0] r;
    r = p;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ ({6'b000000, POLY} << (i - 8));
    end
    return r[7:0];
  endfunction

  logic             advance;
  logic             v1_q, v2_q, out_valid_q;
  logic [7:0]       a1_q, b1_q;
  logic [14:0]      p2_q, p2_d;
  logic [7:0]       y_q, red_d;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       hi_d, lo_d, mid_d;
`ifdef GF8_MAC_EN
  logic             l1_q, l2_q;
  logic [7:0]       acc_q;
`endif

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = rst_n && advance;

  // Karatsuba: middle term recovered from (ah^al)(bh^bl) minus the two outer products.
  assign hi_d  = clmul4(a1_q[7:4], b1_q[7:4]);
  assign lo_d  = clmul4(a1_q[3:0], b1_q[3:0]);
  assign mid_d = clmul4(a1_q[7:4] ^ a1_q[3:0], b1_q[7:4] ^ b1_q[3:0]) ^ hi_d ^ lo_d;
  assign p2_d  = {hi_d, 8'h00} ^ {4'h0, mid_d, 4'h0} ^ {8'h00, lo_d};
  assign red_d = gf_reduce(p2_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      p2_q        <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
`ifdef GF8_MAC_EN
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      acc_q       <= '0;
`endif
    end else begin
      if (advance) begin
        v1_q <= in_valid && in_ready;
        a1_q <= in_a;
        b1_q <= in_b;
        v2_q <= v1_q;
        p2_q <= p2_d;
`ifdef GF8_MAC_EN
        l1_q        <= in_last;
        l2_q        <= l1_q;
        out_valid_q <= v2_q && l2_q;
        // Clearing on transfer is equivalent to clearing on accept: S3 cannot move while the result waits.
        if (v2_q) begin
          if (l2_q) begin
            y_q   <= acc_q ^ red_d;
            acc_q <= '0;
          end else begin
            acc_q <= acc_q ^ red_d;
          end
        end
`else
        out_valid_q <= v2_q;
        if (v2_q) y_q <= red_d;
`endif
      end
      if (out_valid_q && out_ready) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = y_q;
  assign op_count  = cnt_q;
  assign busy      = v1_q || v2_q || out_valid_q;

endmodule
